bcd_updown_counter: RTL and testbench
=====================================

BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 Parameter DIGITS, default 2: number of cascaded BCD decades; legal range 1..8.
REQ-002 Parameter WRAP, default 1: 1 = wrap at either limit, 0 = saturate at either limit.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port en, input, 1: count enable; one step per clock while high.
REQ-006 Port up, input, 1: direction; 1 = increment, 0 = decrement; sampled only when en is high.
REQ-007 Port load, input, 1: synchronous parallel load strobe.
REQ-008 Port load_val, input, 4*DIGITS: BCD load value; digit i occupies bits [4i+3:4i].
REQ-009 Port cnt, output, 4*DIGITS: registered BCD count; digit 0 is least significant.
REQ-010 Port vld, output, 1: registered; high for one cycle when cnt holds a value just produced by a step or load.
REQ-011 Port tc, output, 1: registered terminal-count flag; high for one cycle per limit event.

Function
REQ-012 Priority per clock SHALL be rst > load > en; with none active, cnt, vld and tc SHALL hold / return low as defined below.
REQ-013 Load: cnt <= load_val next cycle; any load_val digit above 9 SHALL be clamped to 9; vld = 1, tc = 0.
REQ-014 Up step: digit 0 increments; each digit at 9 with incoming carry SHALL become 0 and carry into the next digit; latency 1 cycle.
REQ-015 Down step: digit 0 decrements; each digit at 0 with incoming borrow SHALL become 9 and borrow from the next digit; latency 1 cycle.
REQ-016 Up at all-9s (10^DIGITS - 1), WRAP=1: cnt SHALL become 0 and tc = 1 in the same cycle.
REQ-017 Down at all-0s, WRAP=1: cnt SHALL become all-9s and tc = 1 in the same cycle.
REQ-018 WRAP=0 at the corresponding limit: cnt SHALL hold; tc = 1 for every enabled cycle at the limit; vld = 1.
REQ-019 vld SHALL be 1 in the cycle after any accepted load or en step, else 0; vld SHALL not depend on whether cnt changed.
REQ-020 tc SHALL be 0 in every cycle not covered by REQ-016..018.
REQ-021 Direction change between consecutive enabled cycles SHALL take effect immediately with no lost or extra step.
REQ-022 Each cnt digit SHALL never hold a value above 9 under any input sequence.
REQ-023 en deasserted SHALL freeze cnt; up toggling while en = 0 SHALL have no effect.

Reset
REQ-024 rst high at a rising clk edge SHALL set cnt = 0, vld = 0, tc = 0, overriding load and en that cycle.
REQ-025 Reset mid-count SHALL discard any in-progress carry/borrow; first step after release SHALL start from 0.
REQ-026 No output SHALL be undefined after the first clock edge with rst high.

Structure
REQ-027 Package bcd_pkg SHALL hold constants BCD_MAX (4'd9), BCD_MIN (4'd0), DIGIT_W (4) and the clamp function.
REQ-028 Sub-module bcd_digit (one decade: en/up/carry-in in, digit/carry-out out, combinational next-state) SHALL be instantiated DIGITS times via generate; registers reside in bcd_updown_counter.
REQ-029 Carry/borrow chain SHALL be combinational across digits in one cycle; no pipelining.

Verification (DIGITS=2, WRAP=1 unless noted)
REQ-030 rst=1 for 2 cycles with en=1, load=1 -> cnt=00, vld=0, tc=0; release, en=1 up=1 for 10 cycles -> cnt=10, vld=1 each cycle.
REQ-031 load=1 load_val=8'h98, then en=1 up=1 for 2 cycles -> cnt 99 then 00 with tc=1 on the 00 cycle only.
REQ-032 cnt=00, en=1 up=0 -> cnt=99, tc=1; next step -> 98, tc=0.
REQ-033 WRAP=0: load 99, en=1 up=1 for 3 cycles -> cnt stays 99, tc=1 and vld=1 all 3 cycles.
REQ-034 load_val=8'hAF -> cnt=99; load=1 and en=1 same cycle with load_val=8'h42 -> cnt=42 (no step).
REQ-035 Count up to 37, assert rst one cycle mid-count, release -> cnt=00, next step -> 01.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the cascaded BCD up/down counter.
package bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  // Force a possibly non-decimal nibble into the legal 0..9 range.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    if (d > BCD_MAX) begin
      return BCD_MAX;
    end else begin
      return d;
    end
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: combinational next value and carry/borrow to the next decade.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       en_i,
  input  logic       up_i,
  input  logic       cin_i,
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o,
  output logic       cout_o
);

  // Step this decade only when enabled and the lower decades ripple into it.
  always_comb begin
    digit_o = digit_i;
    cout_o  = 1'b0;
    if (en_i && cin_i) begin
      if (up_i) begin
        if (digit_i >= BCD_MAX) begin
          digit_o = BCD_MIN;
          cout_o  = 1'b1;
        end else begin
          digit_o = digit_i + 4'd1;
        end
      end else begin
        if (digit_i == BCD_MIN) begin
          digit_o = BCD_MAX;
          cout_o  = 1'b1;
        end else if (digit_i > BCD_MAX) begin
          // Unreachable with legal state; steer back into range anyway.
          digit_o = BCD_MAX;
        end else begin
          digit_o = digit_i - 4'd1;
        end
      end
    end else begin
      digit_o = digit_i;
      cout_o  = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// Cascaded BCD up/down counter with parallel load, wrap or saturate at the limits.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int WRAP   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   cnt,
  output logic                  vld,
  output logic                  tc
);

  localparam logic WRAP_EN = (WRAP != 0);

  logic [4*DIGITS-1:0] cnt_q;
  logic [4*DIGITS-1:0] cnt_d;
  logic                vld_q;
  logic                vld_d;
  logic                tc_q;
  logic                tc_d;

  // Ripple chain: carry_s[0] feeds the least significant decade, the top bit
  // is the limit event (all-9s going up or all-0s going down).
  logic [DIGITS:0]     carry_s;
  logic [4*DIGITS-1:0] step_s;
  logic                limit_s;

  assign carry_s[0] = 1'b1;
  assign limit_s    = carry_s[DIGITS];

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_digit u_digit (
        .en_i    (en),
        .up_i    (up),
        .cin_i   (carry_s[gi]),
        .digit_i (cnt_q[DIGIT_W*gi +: DIGIT_W]),
        .digit_o (step_s[DIGIT_W*gi +: DIGIT_W]),
        .cout_o  (carry_s[gi+1])
      );
    end
  endgenerate

  // Next state: load beats a count step; idle holds the count and clears flags.
  always_comb begin
    cnt_d = cnt_q;
    vld_d = 1'b0;
    tc_d  = 1'b0;
    if (load) begin
      for (int i = 0; i < DIGITS; i++) begin
        cnt_d[DIGIT_W*i +: DIGIT_W] = clamp_digit(load_val[DIGIT_W*i +: DIGIT_W]);
      end
      vld_d = 1'b1;
      tc_d  = 1'b0;
    end else if (en) begin
      vld_d = 1'b1;
      tc_d  = limit_s;
      if (limit_s && !WRAP_EN) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = step_s;
      end
    end else begin
      cnt_d = cnt_q;
      vld_d = 1'b0;
      tc_d  = 1'b0;
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {(4*DIGITS){1'b0}};
      vld_q <= 1'b0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      vld_q <= vld_d;
      tc_q  <= tc_d;
    end
  end

  assign cnt = cnt_q;
  assign vld = vld_q;
  assign tc  = tc_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Self-checking bench: a wrapping and a saturating 2-digit counter driven by
// the same stimulus, each compared every cycle against an integer model.
module tb_bcd_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [7:0] cnt_w, cnt_s;
  logic       vld_w, vld_s, tc_w, tc_s;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  // Model state: index 0 = wrapping counter, 1 = saturating counter.
  int m_val [2];
  bit m_vld [2];
  bit m_tc  [2];

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIGITS(2), .WRAP(1)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val), .cnt(cnt_w), .vld(vld_w), .tc(tc_w)
  );

  bcd_updown_counter #(.DIGITS(2), .WRAP(0)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val), .cnt(cnt_s), .vld(vld_s), .tc(tc_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic int clamp_val(input logic [7:0] lv);
    int hi;
    int lo;
    hi = (int'(lv[7:4]) > 9) ? 9 : int'(lv[7:4]);
    lo = (int'(lv[3:0]) > 9) ? 9 : int'(lv[3:0]);
    return hi * 10 + lo;
  endfunction

  // Reference model: plain integer counting 0..99 with wrap or saturate.
  always @(posedge clk) begin
    for (int w = 0; w < 2; w++) begin
      if (rst) begin
        m_val[w] <= 0;
        m_vld[w] <= 1'b0;
        m_tc[w]  <= 1'b0;
      end else if (load) begin
        m_val[w] <= clamp_val(load_val);
        m_vld[w] <= 1'b1;
        m_tc[w]  <= 1'b0;
      end else if (en) begin
        m_vld[w] <= 1'b1;
        if (up) begin
          if (m_val[w] == 99) begin
            m_val[w] <= (w == 0) ? 0 : 99;
            m_tc[w]  <= 1'b1;
          end else begin
            m_val[w] <= m_val[w] + 1;
            m_tc[w]  <= 1'b0;
          end
        end else begin
          if (m_val[w] == 0) begin
            m_val[w] <= (w == 0) ? 99 : 0;
            m_tc[w]  <= 1'b1;
          end else begin
            m_val[w] <= m_val[w] - 1;
            m_tc[w]  <= 1'b0;
          end
        end
      end else begin
        m_vld[w] <= 1'b0;
        m_tc[w]  <= 1'b0;
      end
    end
  end

  // Cycle-by-cycle comparison of both counters against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("wrap_cnt", {24'd0, cnt_w}, {24'd0, to_bcd(m_val[0])});
      check("wrap_vld", {31'd0, vld_w}, {31'd0, m_vld[0]});
      check("wrap_tc",  {31'd0, tc_w},  {31'd0, m_tc[0]});
      check("sat_cnt",  {24'd0, cnt_s}, {24'd0, to_bcd(m_val[1])});
      check("sat_vld",  {31'd0, vld_s}, {31'd0, m_vld[1]});
      check("sat_tc",   {31'd0, tc_s},  {31'd0, m_tc[1]});
    end
  end

  // Apply one cycle of inputs, then return at the following falling edge.
  task automatic cyc(input bit r, input bit l, input logic [7:0] lv, input bit e, input bit u);
    rst = r;
    load = l;
    load_val = lv;
    en = e;
    up = u;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    // Reset overrides load and en.
    cyc(1'b1, 1'b1, 8'h55, 1'b1, 1'b1);
    chk_on = 1'b1;
    cyc(1'b1, 1'b1, 8'h55, 1'b1, 1'b1);
    check("rst_cnt", {24'd0, cnt_w}, 32'h00);
    check("rst_vld", {31'd0, vld_w}, 32'd0);
    check("rst_tc",  {31'd0, tc_w},  32'd0);

    // Ten up steps from zero.
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      check("up_vld", {31'd0, vld_w}, 32'd1);
    end
    check("up10_cnt", {24'd0, cnt_w}, 32'h10);

    // Load 98, step through 99 to 00.
    cyc(1'b0, 1'b1, 8'h98, 1'b0, 1'b1);
    check("load98", {24'd0, cnt_w}, 32'h98);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("to99_cnt", {24'd0, cnt_w}, 32'h99);
    check("to99_tc",  {31'd0, tc_w},  32'd0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("wrap00_cnt", {24'd0, cnt_w}, 32'h00);
    check("wrap00_tc",  {31'd0, tc_w},  32'd1);
    check("sat_hold99", {24'd0, cnt_s}, 32'h99);

    // Idle with up toggling: frozen count, flags low.
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("idle_cnt", {24'd0, cnt_w}, 32'h00);
    check("idle_vld", {31'd0, vld_w}, 32'd0);
    check("idle_tc",  {31'd0, tc_w},  32'd0);

    // Down from 00 wraps to 99, then 98.
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("down99_cnt", {24'd0, cnt_w}, 32'h99);
    check("down99_tc",  {31'd0, tc_w},  32'd1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("down98_cnt", {24'd0, cnt_w}, 32'h98);
    check("down98_tc",  {31'd0, tc_w},  32'd0);

    // Saturating counter at 99 going up three times.
    cyc(1'b0, 1'b1, 8'h99, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      check("sat_up_cnt", {24'd0, cnt_s}, 32'h99);
      check("sat_up_tc",  {31'd0, tc_s},  32'd1);
      check("sat_up_vld", {31'd0, vld_s}, 32'd1);
    end

    // Saturating counter at 00 going down.
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("sat_dn_cnt", {24'd0, cnt_s}, 32'h00);
    check("sat_dn_tc",  {31'd0, tc_s},  32'd1);

    // Load clamping, and load winning over en.
    cyc(1'b0, 1'b1, 8'hAF, 1'b0, 1'b0);
    check("clampAF", {24'd0, cnt_w}, 32'h99);
    cyc(1'b0, 1'b1, 8'h42, 1'b1, 1'b1);
    check("load_vs_en", {24'd0, cnt_w}, 32'h42);
    check("load_tc",    {31'd0, tc_w},  32'd0);

    // Reset mid-count discards progress.
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 37; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("up37", {24'd0, cnt_w}, 32'h37);
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    check("midrst_cnt", {24'd0, cnt_w}, 32'h00);
    check("midrst_vld", {31'd0, vld_w}, 32'd0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("after_rst", {24'd0, cnt_w}, 32'h01);

    // Randomized traffic, checked every cycle by the compare process.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) == 0),
          ($urandom_range(0, 15) == 0),
          8'($urandom),
          ($urandom_range(0, 3) != 0),
          1'($urandom));
    end

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
